arbiter_response_router: RTL and testbench

Returns responses to the channel that won arbitration, in grant order. Sits beside a static-priority or timeout-priority arbiter: each accepted grant is recorded in an in-order queue, and each response from the shared downstream resource goes back to the oldest recorded channel. It is the return path of the arbitrated request interface.

---
 rtl/arbiter_response_router_pkg.sv | 16 +
 rtl/arbiter_response_router_onehot_to_binary.sv | 25 ++
 rtl/arbiter_response_router.sv | 120 ++++++++++++
 tb/tb_arbiter_response_router.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_response_router_pkg.sv
// Shared helpers for the arbiter response router.
// Width math used by the router and its index encoder.
package arbiter_response_router_pkg;

    localparam int unsigned DEF_SIZE       = 4;
    localparam int unsigned DEF_DEPTH      = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/arbiter_response_router_onehot_to_binary.sv
// One-hot to binary index encoder.
// valid_onehot is high only when exactly one bit is set.
import arbiter_response_router_pkg::*;

module onehot_to_binary #(
    parameter int SIZE = DEF_SIZE
) (
    input  logic [SIZE-1:0]        onehot,
    output logic [clog2(SIZE)-1:0] index,
    output logic                   valid_onehot
);

    localparam int IDX_W = clog2(SIZE);

    always_comb begin
        index = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (onehot[i]) index = index | IDX_W'(i);
        end
    end

    assign valid_onehot = (onehot != '0) &&
                          ((onehot & (onehot - SIZE'(1))) == '0);

endmodule

// File: rtl/arbiter_response_router.sv
// Routes shared responses back to granted channels in grant order.
// Grant order is held in an inline circular queue of channel indices.
import arbiter_response_router_pkg::*;

module arbiter_response_router #(
    parameter int SIZE       = DEF_SIZE,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SIZE-1:0]       grant,
    input  logic                  grant_valid,
    output logic                  grant_ready,
    input  logic                  response_valid,
    output logic                  response_ready,
    input  logic [DATA_WIDTH-1:0] response_data,
    output logic [SIZE-1:0]       channel_response_valid,
    input  logic [SIZE-1:0]       channel_response_ready,
    output logic [DATA_WIDTH-1:0] channel_response_data,
    output logic                  full,
    output logic                  empty,
    output logic                  grant_error,
    output logic                  response_error
);

    localparam int IDX_W = clog2(SIZE);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [IDX_W-1:0] queue_q [DEPTH];
    logic [IDX_W-1:0] queue_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             grant_error_q, grant_error_d;
    logic             response_error_q, response_error_d;

    logic [IDX_W-1:0] grant_idx;
    logic             grant_onehot;
    logic [IDX_W-1:0] head;
    logic             push;
    logic             pop;

    onehot_to_binary #(.SIZE(SIZE)) u_enc (
        .onehot       (grant),
        .index        (grant_idx),
        .valid_onehot (grant_onehot)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Push is gated only by registered full, so no response-to-grant path
    assign grant_ready = !full_q;
    assign push        = grant_valid && grant_ready && grant_onehot;
    assign head        = queue_q[rd_ptr_q];

    assign response_ready = !empty_q && channel_response_ready[head];
    assign pop            = response_valid && response_ready;

    assign channel_response_data = response_data;

    always_comb begin
        channel_response_valid = '0;
        if (response_valid && !empty_q) channel_response_valid[head] = 1'b1;
    end

    always_comb begin
        queue_d  = queue_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            queue_d[wr_ptr_q] = grant_idx;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d           = (count_d == CNT_W'(DEPTH));
        empty_d          = (count_d == '0);
        grant_error_d    = grant_valid && !grant_onehot;
        response_error_d = response_valid && empty_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            full_q           <= 1'b0;
            empty_q          <= 1'b1;
            grant_error_q    <= 1'b0;
            response_error_q <= 1'b0;
        end else begin
            queue_q          <= queue_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            full_q           <= full_d;
            empty_q          <= empty_d;
            grant_error_q    <= grant_error_d;
            response_error_q <= response_error_d;
        end
    end

    assign full           = full_q;
    assign empty          = empty_q;
    assign grant_error    = grant_error_q;
    assign response_error = response_error_q;

endmodule

// File: tb/tb_arbiter_response_router.sv
// Directed bench for arbiter_response_router (SIZE=4, DEPTH=8).
// Each scenario task drives its stimulus and checks inline.
module tb_arbiter_response_router;

    logic        clock;
    logic        reset;
    logic [3:0]  grant;
    logic        grant_valid;
    logic        grant_ready;
    logic        response_valid;
    logic        response_ready;
    logic [31:0] response_data;
    logic [3:0]  channel_response_valid;
    logic [3:0]  channel_response_ready;
    logic [31:0] channel_response_data;
    logic        full;
    logic        empty;
    logic        grant_error;
    logic        response_error;

    int n_cmp = 0;
    int n_bad = 0;

    arbiter_response_router #(.SIZE(4), .DEPTH(8), .DATA_WIDTH(32)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .grant                  (grant),
        .grant_valid            (grant_valid),
        .grant_ready            (grant_ready),
        .response_valid         (response_valid),
        .response_ready         (response_ready),
        .response_data          (response_data),
        .channel_response_valid (channel_response_valid),
        .channel_response_ready (channel_response_ready),
        .channel_response_data  (channel_response_data),
        .full                   (full),
        .empty                  (empty),
        .grant_error            (grant_error),
        .response_error         (response_error)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; grant = 0; grant_valid = 0;
        response_valid = 0; response_data = 0;
        channel_response_ready = 0;
        #3;
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++;
            $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++;
        if (full !== 1'b0) begin n_bad++;
            $display("FAIL reset_full got %b want 0", full); end
        n_cmp++;
        if (grant_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_grant_ready got %b want 1", grant_ready); end
        n_cmp++;
        if (response_ready !== 1'b0) begin n_bad++;
            $display("FAIL reset_resp_ready got %b want 0", response_ready); end
        n_cmp++;
        if (channel_response_valid !== 4'b0000) begin n_bad++;
            $display("FAIL reset_crv got %b want 0000", channel_response_valid); end
        n_cmp++;
        if ({grant_error, response_error} !== 2'b00) begin n_bad++;
            $display("FAIL reset_errors got %b want 00",
                     {grant_error, response_error}); end
        @(posedge clock);
        #1 reset = 0;
    endtask

    task automatic test_single();
        grant = 4'b0100; grant_valid = 1;
        tick();
        grant_valid = 0; grant = 0;
        response_valid = 1; response_data = 32'hA5;
        channel_response_ready = 4'b0100;
        #1;
        n_cmp++;
        if (channel_response_valid !== 4'b0100) begin n_bad++;
            $display("FAIL single_crv got %b want 0100", channel_response_valid); end
        n_cmp++;
        if (channel_response_data !== 32'hA5) begin n_bad++;
            $display("FAIL single_data got %h want a5", channel_response_data); end
        n_cmp++;
        if (response_ready !== 1'b1) begin n_bad++;
            $display("FAIL single_ready got %b want 1", response_ready); end
        tick();
        response_valid = 0;
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++;
            $display("FAIL single_empty_after got %b want 1", empty); end
    endtask

    task automatic test_ordering();
        logic [3:0] gseq [4];
        gseq[0] = 4'b0100; gseq[1] = 4'b0001;
        gseq[2] = 4'b1000; gseq[3] = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            grant = gseq[i]; grant_valid = 1;
            tick();
        end
        grant_valid = 0; grant = 0;
        response_valid = 1; channel_response_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            response_data = 32'h100 + i;
            #1;
            n_cmp++;
            if (channel_response_valid !== gseq[i]) begin n_bad++;
                $display("FAIL order_%0d got %b want %b", i,
                         channel_response_valid, gseq[i]); end
            tick();
        end
        response_valid = 0;
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++;
            $display("FAIL order_empty got %b want 1", empty); end
    endtask

    task automatic test_backpressure();
        grant = 4'b0010; grant_valid = 1;
        tick();
        grant_valid = 0; grant = 0;
        response_valid = 1; response_data = 32'h55;
        channel_response_ready = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (response_ready !== 1'b0 || channel_response_valid !== 4'b0010)
            begin n_bad++;
                $display("FAIL bp_stall_%0d ready %b crv %b want 0 0010", i,
                         response_ready, channel_response_valid); end
            tick();
            n_cmp++;
            if (empty !== 1'b0) begin n_bad++;
                $display("FAIL bp_held_%0d empty %b want 0", i, empty); end
        end
        channel_response_ready = 4'b0010;
        #1;
        n_cmp++;
        if (response_ready !== 1'b1) begin n_bad++;
            $display("FAIL bp_release got %b want 1", response_ready); end
        tick();
        response_valid = 0;
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++;
            $display("FAIL bp_popped empty %b want 1", empty); end
    endtask

    task automatic test_full_wrap();
        int q[$];
        int ch;
        for (int i = 0; i < 8; i++) begin
            ch = (i * 3) % 4;
            grant = 4'(1 << ch); grant_valid = 1;
            q.push_back(ch);
            tick();
        end
        grant_valid = 0;
        #1;
        n_cmp++;
        if (full !== 1'b1 || grant_ready !== 1'b0) begin n_bad++;
            $display("FAIL full_flags full %b gready %b want 1 0",
                     full, grant_ready); end
        grant = 4'b0100; grant_valid = 1;
        tick();
        grant_valid = 0;
        n_cmp++;
        if (full !== 1'b1) begin n_bad++;
            $display("FAIL full_ninth full %b want 1", full); end
        response_valid = 1; channel_response_ready = 4'b1111;
        #1;
        n_cmp++;
        if (channel_response_valid !== 4'(1 << q[0])) begin n_bad++;
            $display("FAIL full_pop got %b want %b",
                     channel_response_valid, 4'(1 << q[0])); end
        tick();
        void'(q.pop_front());
        for (int k = 0; k < 20; k++) begin
            ch = (k + 1) % 4;
            grant = 4'(1 << ch); grant_valid = 1;
            #1;
            n_cmp++;
            if (channel_response_valid !== 4'(1 << q[0]) || grant_ready !== 1'b1)
            begin n_bad++;
                $display("FAIL wrap_%0d crv %b gready %b want %b 1", k,
                         channel_response_valid, grant_ready, 4'(1 << q[0])); end
            tick();
            void'(q.pop_front());
            q.push_back(ch);
        end
        grant_valid = 0; grant = 0;
        while (q.size() > 0) begin
            #1;
            n_cmp++;
            if (channel_response_valid !== 4'(1 << q[0])) begin n_bad++;
                $display("FAIL drain_%0d got %b want %b", q.size(),
                         channel_response_valid, 4'(1 << q[0])); end
            tick();
            void'(q.pop_front());
        end
        response_valid = 0;
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++;
            $display("FAIL drain_empty got %b want 1", empty); end
    endtask

    task automatic test_errors();
        grant = 4'b0110; grant_valid = 1;
        tick();
        grant_valid = 0; grant = 0;
        n_cmp++;
        if (grant_error !== 1'b1 || empty !== 1'b1) begin n_bad++;
            $display("FAIL gerr_pulse gerr %b empty %b want 1 1",
                     grant_error, empty); end
        tick();
        n_cmp++;
        if (grant_error !== 1'b0) begin n_bad++;
            $display("FAIL gerr_clear got %b want 0", grant_error); end
        grant = 4'b0000; grant_valid = 1;
        tick();
        grant_valid = 0;
        n_cmp++;
        if (grant_error !== 1'b1 || empty !== 1'b1) begin n_bad++;
            $display("FAIL gerr_zero gerr %b empty %b want 1 1",
                     grant_error, empty); end
        response_valid = 1; channel_response_ready = 4'b1111;
        #1;
        n_cmp++;
        if (response_ready !== 1'b0 || channel_response_valid !== 4'b0000)
        begin n_bad++;
            $display("FAIL rerr_ready ready %b crv %b want 0 0000",
                     response_ready, channel_response_valid); end
        tick();
        response_valid = 0;
        n_cmp++;
        if (response_error !== 1'b1) begin n_bad++;
            $display("FAIL rerr_pulse got %b want 1", response_error); end
        tick();
        n_cmp++;
        if (response_error !== 1'b0) begin n_bad++;
            $display("FAIL rerr_clear got %b want 0", response_error); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            grant = 4'(1 << ((i + 1) % 4)); grant_valid = 1;
            tick();
        end
        grant_valid = 0; grant = 0;
        response_valid = 1; channel_response_ready = 4'b0000;
        #1;
        n_cmp++;
        if (channel_response_valid !== 4'b0010 || empty !== 1'b0) begin n_bad++;
            $display("FAIL rmid_pre crv %b empty %b want 0010 0",
                     channel_response_valid, empty); end
        #1 reset = 1;
        #1;
        n_cmp++;
        if (empty !== 1'b1 || channel_response_valid !== 4'b0000) begin n_bad++;
            $display("FAIL rmid_async empty %b crv %b want 1 0000",
                     empty, channel_response_valid); end
        #1 reset = 0;
        channel_response_ready = 4'b1111;
        tick();
        n_cmp++;
        if (response_error !== 1'b1) begin n_bad++;
            $display("FAIL rmid_rerr got %b want 1", response_error); end
        response_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_ordering();
        test_backpressure();
        test_full_wrap();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
